// File: rtl/ex_mem1_load_stage_pkg.sv
// Shared types for the EX->MEM1 load stage: funct3 codes,
// FSM encoding, captured-op bundle and alignment helpers.
package ex_mem1_load_stage_pkg;

  localparam int MEM1_RD_W = 5;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } ld_funct3_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_MISS   = 2'd2
  } mem1_state_e;

  typedef struct packed {
    ld_funct3_e           funct3;
    logic [1:0]           offset;
    logic [MEM1_RD_W-1:0] rd;
    logic                 is_load;
  } mem1_op_t;

  function automatic logic mem1_misaligned(
    input ld_funct3_e f,
    input logic [1:0] off
  );
    logic half, word;
    half = f inside {F3_LH, F3_LHU};
    word = (f == F3_LW);
    return (half && off[0]) || (word && (off != 2'b00));
  endfunction

endpackage

// File: rtl/ex_mem1_load_stage_if.sv
// EX request, dcache response and writeback bundle for MEM1.
// MEM1_MISALIGN_TRAP_EN adds the o_misalign trap line.
interface ex_mem1_load_stage_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  logic            i_valid;
  logic            i_is_load;
  logic [2:0]      i_funct3;
  logic [1:0]      i_mem_addr;
  logic [RD_W-1:0] i_rd;
  logic            i_flush;
  logic            i_dc_hit;
  logic [XLEN-1:0] i_dc_rdata;
  logic            i_dc_refill_valid;
  logic            o_stall;
  logic            o_wb_valid;
  logic [RD_W-1:0] o_wb_rd;
  logic [XLEN-1:0] o_wb_data;
  logic            o_tmo_err;

`ifdef MEM1_MISALIGN_TRAP_EN
  logic            o_misalign;

  modport master (
    output i_valid, i_is_load, i_funct3,
    output i_mem_addr, i_rd, i_flush,
    output i_dc_hit, i_dc_rdata,
    output i_dc_refill_valid,
    input  o_stall, o_wb_valid, o_wb_rd,
    input  o_wb_data, o_tmo_err, o_misalign
  );

  modport slave (
    input  i_valid, i_is_load, i_funct3,
    input  i_mem_addr, i_rd, i_flush,
    input  i_dc_hit, i_dc_rdata,
    input  i_dc_refill_valid,
    output o_stall, o_wb_valid, o_wb_rd,
    output o_wb_data, o_tmo_err, o_misalign
  );
`else
  modport master (
    output i_valid, i_is_load, i_funct3,
    output i_mem_addr, i_rd, i_flush,
    output i_dc_hit, i_dc_rdata,
    output i_dc_refill_valid,
    input  o_stall, o_wb_valid, o_wb_rd,
    input  o_wb_data, o_tmo_err
  );

  modport slave (
    input  i_valid, i_is_load, i_funct3,
    input  i_mem_addr, i_rd, i_flush,
    input  i_dc_hit, i_dc_rdata,
    input  i_dc_refill_valid,
    output o_stall, o_wb_valid, o_wb_rd,
    output o_wb_data, o_tmo_err
  );
`endif

endinterface

// File: rtl/ex_mem1_load_stage_align.sv
// Combinational load aligner: picks byte/half/word from a
// word-aligned dcache word and sign/zero-extends it.
import ex_mem1_load_stage_pkg::*;

module ex_mem1_load_stage_align #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  ld_funct3_e      funct3,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] data
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        is_b;
  logic        is_h;
  logic        sx;

  assign b    = word[{offset, 3'b000} +: 8];
  assign h    = word[{offset[1], 4'b0000} +: 16];
  assign is_b = funct3 inside {F3_LB, F3_LBU};
  assign is_h = funct3 inside {F3_LH, F3_LHU};
  assign sx   = !funct3[2];

  always_comb begin
    data = word;
    unique case (1'b1)
      is_b:    data = {{(XLEN-8){sx & b[7]}}, b};
      is_h:    data = {{(XLEN-16){sx & h[15]}}, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/ex_mem1_load_stage.sv
// MEM1 load stage: dcache lookup, miss wait and load writeback.
// Optional MEM1_MISALIGN_TRAP_EN traps misaligned half/word ops.
import ex_mem1_load_stage_pkg::*;

module ex_mem1_load_stage #(
  parameter int XLEN     = 32,
  parameter int RD_W     = MEM1_RD_W,
  parameter int MISS_TMO = 255
) (
  input logic                clk,
  input logic                rst,
  ex_mem1_load_stage_if.slave bus
);

  localparam int CNT_W = $clog2(MISS_TMO + 1);

  mem1_state_e     state_q;
  mem1_state_e     state_d;
  mem1_op_t        op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] algn;
  logic            cap;
  logic            live;
  logic            miss_go;
  logic            wb_go;
  logic            stall;
  logic            tmo;
  logic            mis;
  logic            wb_valid;
  logic [RD_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            tmo_err;

`ifdef MEM1_MISALIGN_TRAP_EN
  assign mis = (state_q == S_LOOKUP) && !bus.i_flush
            && mem1_misaligned(op_q.funct3, op_q.offset);
  assign bus.o_misalign = mis;
`else
  assign mis = 1'b0;
`endif

  // A missing load stalls EX in the very lookup cycle.
  assign cap = bus.i_valid && !bus.i_flush && !stall;
  assign tmo = (state_q == S_MISS)
            && !bus.i_dc_refill_valid
            && (cnt_q == CNT_W'(MISS_TMO - 1));

  ex_mem1_load_stage_align #(
    .XLEN (XLEN)
  ) u_align (
    .word   (bus.i_dc_rdata),
    .funct3 (op_q.funct3),
    .offset (op_q.offset),
    .data   (algn)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cap) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (miss_go)  state_d = S_MISS;
        else if (cap) state_d = S_LOOKUP;
        else          state_d = S_IDLE;
      end
      S_MISS: begin
        if (bus.i_dc_refill_valid || tmo)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    live    = 1'b0;
    miss_go = 1'b0;
    wb_go   = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      S_LOOKUP: begin
        live    = op_q.is_load && !bus.i_flush && !mis;
        miss_go = live && !bus.i_dc_hit;
        wb_go   = live && bus.i_dc_hit;
        stall   = miss_go;
      end
      S_MISS: begin
        stall = 1'b1;
        wb_go = bus.i_dc_refill_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      cnt_q    <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      tmo_err  <= 1'b0;
    end else begin
      if (cap) begin
        op_q <= '{
          funct3:  ld_funct3_e'(bus.i_funct3),
          offset:  bus.i_mem_addr,
          rd:      bus.i_rd,
          is_load: bus.i_is_load
        };
      end
      if (state_q == S_MISS && state_d == S_MISS)
        cnt_q <= cnt_q + CNT_W'(1);
      else
        cnt_q <= '0;
      wb_valid <= wb_go;
      if (wb_go) begin
        wb_rd   <= op_q.rd;
        wb_data <= algn;
      end
      if (tmo) tmo_err <= 1'b1;
    end
  end

  assign bus.o_stall    = stall;
  assign bus.o_wb_valid = wb_valid;
  assign bus.o_wb_rd    = wb_rd;
  assign bus.o_wb_data  = wb_data;
  assign bus.o_tmo_err  = tmo_err;

endmodule
